// File: rtl/seg_scan_sched.sv
// seg_scan_sched: 8-digit multiplexed seven-segment scan scheduler with a double-buffered
// value input and frame-aligned swaps. Optional macro: SEG_LEADING_ZERO_BLANK_EN.
`default_nettype none

module seg_scan_sched #(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_i,
  input  logic [7:0]  dp_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  seg_o,
  output logic [7:0]  an_o,
  output logic        frame_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST       = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_PRE_LAST   = CW'(DIV - 2);
  localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK - 1);

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    dig;
  logic [31:0]   disp;
  logic [7:0]    disp_dp;
  logic [31:0]   pend;
  logic [7:0]    pend_dp;
  logic          pend_full;

  logic          boundary;
  logic [3:0]    nib;
  logic [7:0]    pattern;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign boundary = (cnt == CNT_LAST) && (dig == 3'd7);
  assign nib      = disp[{dig, 2'b00} +: 4];
  assign ready_o  = !pend_full;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [2:0] top;

  // Index of the most significant nonzero nibble; 0 when the whole word is zero.
  always_comb begin
    top = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (disp[4*k +: 4] != 4'd0) top = 3'(k);
    end
  end

  always_comb begin
    pattern = {~disp_dp[dig], hex_to_seg(nib)};
    if ((dig > top) && !disp_dp[dig]) pattern = 8'hFF;
  end
`else
  always_comb begin
    pattern = {~disp_dp[dig], hex_to_seg(nib)};
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_BLANK;
      cnt       <= '0;
      dig       <= 3'd0;
      disp      <= 32'd0;
      disp_dp   <= 8'd0;
      pend      <= 32'd0;
      pend_dp   <= 8'd0;
      pend_full <= 1'b0;
      seg_o     <= 8'hFF;
      an_o      <= 8'hFF;
      frame_o   <= 1'b0;
    end else begin
      case (state)
        S_BLANK: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_BLANK_LAST) state <= S_SHOW;
        end
        default: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            dig   <= dig + 3'd1;
            state <= S_BLANK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase

      // Registered one cycle early so the pulse lines up with the boundary cycle itself.
      frame_o <= (cnt == CNT_PRE_LAST) && (dig == 3'd7);

      if (state == S_SHOW) begin
        an_o  <= ~(8'b1 << dig);
        seg_o <= pattern;
      end else begin
        an_o  <= 8'hFF;
        seg_o <= 8'hFF;
      end

      // A full pend swaps at the boundary; an empty pend may still be loaded there.
      if (boundary && pend_full) begin
        disp      <= pend;
        disp_dp   <= pend_dp;
        pend_full <= 1'b0;
      end else if (valid_i && !pend_full) begin
        pend      <= value_i;
        pend_dp   <= dp_i;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_sched.sv
// tb_seg_scan_sched: scoreboard bench; stimulus queues expected digit slots per frame,
// a monitor pops one entry whenever a lit slot begins on an_o.
`default_nettype none

module tb_seg_scan_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] value_i = 32'd0;
  logic [7:0]  dp_i = 8'd0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [7:0]  seg_o;
  logic [7:0]  an_o;
  logic        frame_o;

  seg_scan_sched #(.DIV(8), .BLANK(2)) dut (
    .clk(clk), .rst(rst), .value_i(value_i), .dp_i(dp_i), .valid_i(valid_i),
    .ready_o(ready_o), .seg_o(seg_o), .an_o(an_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
  } ent_t;

  ent_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input logic [31:0] v, input logic [7:0] dp, input int d);
    logic [7:0] p;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    int top = 0;
    for (int k = 1; k < 8; k++) if (v[4*k +: 4] != 4'd0) top = k;
    if (d > top && !dp[d]) return 8'hFF;
`endif
    p = hex7(v[4*d +: 4]);
    p[7] = ~dp[d];
    return p;
  endfunction

  task automatic push_frame(input logic [31:0] v, input logic [7:0] dp);
    ent_t e;
    for (int d = 0; d < 8; d++) begin
      e.an  = ~(8'b1 << d);
      e.seg = exp_seg(v, dp, d);
      q.push_back(e);
    end
  endtask

  task automatic wait_p(input int target);
    int g = 0;
    while (cyc != target && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) check("wait_timeout", cyc, target);
  endtask

  // Monitor
  logic       lit, prev_lit, first, stable;
  int         run, blank_run;
  logic       fexp;
  logic [7:0] cur_an, cur_seg;
  ent_t       e_pop;

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      prev_lit  = 1'b0;
      first     = 1'b1;
      blank_run = 0;
      run       = 0;
    end else begin
      lit  = (an_o != 8'hFF);
      fexp = ((cyc % 64) == 63);
      if (frame_o || fexp) check("frame_o", frame_o, fexp);
      if (lit && !prev_lit) begin
        if (!first) check("blank_len", blank_run, 2);
        first = 1'b0;
        check("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e_pop = q.pop_front();
          check("an", an_o, e_pop.an);
          check("seg", seg_o, e_pop.seg);
        end
        run     = 1;
        stable  = 1'b1;
        cur_an  = an_o;
        cur_seg = seg_o;
      end else if (lit) begin
        run++;
        if (an_o != cur_an || seg_o != cur_seg) stable = 1'b0;
      end else if (prev_lit) begin
        check("lit_len", run, 6);
        check("lit_stable", stable, 1);
        blank_run = 1;
      end else begin
        blank_run++;
      end
      if (!lit) check("seg_blank", seg_o, 8'hFF);
      prev_lit = lit;
    end
  end

  initial begin
    int g;
    repeat (3) @(negedge clk);
    check("rst_an", an_o, 8'hFF);
    check("rst_seg", seg_o, 8'hFF);
    check("rst_ready", ready_o, 1);
    check("rst_frame", frame_o, 0);
    rst = 1'b1;
    push_frame(32'd0, 8'd0);

    // Frame 0: load, then a second transfer held by back-pressure.
    wait_p(5);
    value_i = 32'h12345678; dp_i = 8'h00; valid_i = 1'b1;
    check("ready_idle", ready_o, 1);
    @(negedge clk);
    valid_i = 1'b0;
    check("ready_full", ready_o, 0);
    wait_p(10);
    value_i = 32'h000000A5; dp_i = 8'h00; valid_i = 1'b1;
    check("ready_bp", ready_o, 0);
    g = 0;
    while (!ready_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("accept_cycle", cyc, 64);
    push_frame(32'h12345678, 8'h00);
    @(negedge clk);
    valid_i = 1'b0;
    check("ready_after_accept", ready_o, 0);

    wait_p(129);
    push_frame(32'h000000A5, 8'h00);

    // Transfer in the boundary cycle with pend empty: held one extra frame.
    wait_p(191);
    value_i = 32'h00000000; dp_i = 8'h01; valid_i = 1'b1;
    check("collision_ready", ready_o, 1);
    check("collision_frame", frame_o, 1);
    @(negedge clk);
    valid_i = 1'b0;
    check("collision_pend", ready_o, 0);
    push_frame(32'h000000A5, 8'h00);

    wait_p(257);
    push_frame(32'h00000000, 8'h01);
    wait_p(260);
    value_i = 32'hFEDCBA90; dp_i = 8'hA0; valid_i = 1'b1;
    check("ready_f4", ready_o, 1);
    @(negedge clk);
    valid_i = 1'b0;

    wait_p(321);
    push_frame(32'hFEDCBA90, 8'hA0);
    wait_p(325);
    value_i = 32'h11111111; dp_i = 8'hFF; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;

    // Asynchronous reset in the middle of a lit slot with pend full.
    wait_p(332);
    check("pre_rst_lit", an_o, 8'hFD);
    #2 rst = 1'b0;
    #1;
    check("arst_an", an_o, 8'hFF);
    check("arst_seg", seg_o, 8'hFF);
    check("arst_ready", ready_o, 1);
    check("arst_frame", frame_o, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push_frame(32'd0, 8'd0);
    wait_p(65);
    push_frame(32'd0, 8'd0);
    wait_p(130);
    check("sb_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
